aes_spi_ctrl: RTL and testbench
===============================

AES_SPI_CTRL -- requirements
Module: aes_spi_ctrl

Interface
REQ-001 SHALL have parameter Nk, default 4, key length in 32-bit words (legal values 4, 6, 8).
REQ-002 SHALL have parameter Nr, default 10, round count; passed through for the core, no function inside this block.
REQ-003 SHALL have parameter TIMEOUT, default 64, maximum wait cycles for aes_done.
REQ-004 SHALL have port clk  in  1  system clock; also the serial bit clock.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port CS  in  1  chip select, active-low.
REQ-007 SHALL have port SDI  in  1  serial data in, MSB first.
REQ-008 SHALL have port SDO  out  1  serial data out, MSB first.
REQ-009 SHALL have port aes_start  out  1  one-cycle start pulse to the AES core.
REQ-010 SHALL have port aes_plaintext  out  128  plaintext to the core.
REQ-011 SHALL have port aes_key  out  32*Nk  key to the core.
REQ-012 SHALL have port aes_done  in  1  core completion strobe.
REQ-013 SHALL have port aes_ciphertext  in  128  core result, valid with aes_done.
REQ-014 SHALL have port busy  out  1  high in LAUNCH and WAIT.
REQ-015 SHALL have port result_valid  out  1  high in TX.
REQ-016 SHALL have port err  out  1  one-cycle pulse on frame abort or timeout.

Function
REQ-017 SHALL implement states IDLE, RX, LAUNCH, WAIT, TX.
REQ-018 SHALL define FRAME = 128+32*Nk bits: plaintext first, then key, each MSB first.
REQ-019 IDLE: on a clk with CS=0, SHALL shift in SDI, set the bit count to 1 and enter RX.
REQ-020 RX: each clk with CS=0 SHALL shift SDI into the frame register and increment the count; capturing bit FRAME SHALL enter LAUNCH on the next edge.
REQ-021 RX: CS=1 before FRAME bits are captured SHALL pulse err, clear the count and return to IDLE; aes_start SHALL NOT be asserted.
REQ-022 LAUNCH: SHALL assert aes_start for exactly one cycle, then enter WAIT.
REQ-023 aes_plaintext and aes_key SHALL remain stable from LAUNCH until WAIT exits.
REQ-024 WAIT: SHALL ignore CS and SDI, count cycles, and on aes_done load aes_ciphertext into the TX shift register and enter TX.
REQ-025 WAIT: TIMEOUT cycles without aes_done SHALL pulse err and return to IDLE.
REQ-026 aes_done outside WAIT SHALL be ignored.
REQ-027 TX: SDO SHALL equal the TX register MSB.
REQ-028 TX: each clk with CS=0 SHALL shift the TX register left; after 128 shifts the block SHALL return to IDLE.
REQ-029 TX: CS=1 SHALL pause shifting with SDO held; shifting SHALL resume on CS=0, with no error.
REQ-030 SDO SHALL be 0 in every state except TX.
REQ-031 The bit counter SHALL be wide enough for 384 and SHALL NOT wrap.

Reset
REQ-032 rst SHALL asynchronously force state IDLE and clear all registers, counters and outputs to 0.
REQ-033 rst asserted mid-RX, WAIT or TX SHALL discard the frame or result, with no err pulse.

Structure
REQ-034 Package aes_pkg SHALL hold the state encoding, the FRAME width function and the TIMEOUT default.
REQ-035 Shift register plus counter SHALL be sub-module aes_spi_shreg, instantiated once for RX and once for TX.

Verification
REQ-036 Nk=4: shift frame 00112233445566778899aabbccddeeff + key 000102030405060708090a0b0c0d0e0f; model core returns done after 10 cycles -> exactly one aes_start, and 128 SDO bits = 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-037 Nk=4: CS=1 after 100 bits -> one err pulse, return to IDLE, no aes_start.
REQ-038 Model core never asserts done -> err pulse 64 cycles after entering WAIT, then IDLE.
REQ-039 TX: CS=1 for 5 cycles after 40 bits -> SDO holds; remaining 88 bits correct.
REQ-040 rst asserted during WAIT -> all outputs 0 immediately; the next full frame operates normally.
REQ-041 Nk=8: 384-bit frame -> aes_key equals the last 256 bits shifted in.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared definitions for the SPI front end of the AES core: state encoding,
// frame sizing and default timing.
package aes_pkg;

    localparam int unsigned BLOCK_W         = 128;
    localparam int unsigned CNT_W           = 9;
    localparam int unsigned TIMEOUT_DEFAULT = 64;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RX     = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_WAIT   = 3'd3,
        ST_TX     = 3'd4
    } state_t;

    // Serial frame length: one plaintext block followed by the key.
    function automatic int unsigned frame_bits(input int unsigned nk);
        return BLOCK_W + 32 * nk;
    endfunction

endpackage

// File: rtl/aes_spi_shreg.sv
// Left-shifting register with a saturating bit counter; exposes its upper
// OUT_W bits so a serialiser can take just the MSB.
module aes_spi_shreg
    import aes_pkg::*;
#(
    parameter int unsigned W     = 128,
    parameter int unsigned OUT_W = W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [W-1:0]     load_data,
    input  logic             shift,
    input  logic             restart,
    input  logic             din,
    output logic [OUT_W-1:0] top_bits,
    output logic [CNT_W-1:0] count
);

    logic [W-1:0] data;

    // clear beats load beats shift; restart makes this shift the first bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data  <= '0;
            count <= '0;
        end else if (clr) begin
            data  <= '0;
            count <= '0;
        end else if (load) begin
            data  <= load_data;
            count <= '0;
        end else if (shift) begin
            data <= {data[W-2:0], din};
            if (restart) begin
                count <= CNT_W'(1);
            end else if (count != {CNT_W{1'b1}}) begin
                count <= count + CNT_W'(1);
            end
        end
    end

    assign top_bits = data[W-1 -: OUT_W];

endmodule

// File: rtl/aes_spi_ctrl.sv
// SPI-style front end for an AES core: receives plaintext+key serially,
// launches the core, waits with a timeout and shifts the ciphertext back out.
module aes_spi_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned Nk      = 4,
    parameter int unsigned Nr      = 10,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                CS,
    input  logic                SDI,
    output logic                SDO,
    output logic                aes_start,
    output logic [BLOCK_W-1:0]  aes_plaintext,
    output logic [32*Nk-1:0]    aes_key,
    input  logic                aes_done,
    input  logic [BLOCK_W-1:0]  aes_ciphertext,
    output logic                busy,
    output logic                result_valid,
    output logic                err
);

    localparam int unsigned FRAME  = frame_bits(Nk);
    localparam int unsigned KEY_W  = 32 * Nk;
    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    if (!(Nk == 4 || Nk == 6 || Nk == 8) || Nr == 0 || TIMEOUT == 0) begin : g_bad_params
        $error("aes_spi_ctrl: unsupported Nk/Nr/TIMEOUT");
    end

    state_t             state;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [FRAME-1:0]   rx_frame;
    logic [CNT_W-1:0]   rx_count;
    logic [CNT_W-1:0]   tx_count;
    logic               tx_msb;

    logic rx_shift_c, rx_restart_c, rx_clr_c, tx_load_c, tx_shift_c;

    assign rx_restart_c = (state == ST_IDLE);
    assign rx_shift_c   = !CS && (state == ST_IDLE || state == ST_RX);
    assign rx_clr_c     = CS && (state == ST_RX);
    assign tx_load_c    = aes_done && (state == ST_WAIT);
    assign tx_shift_c   = !CS && (state == ST_TX);

    aes_spi_shreg #(.W(FRAME), .OUT_W(FRAME)) u_rx (
        .clk       (clk),
        .rst       (rst),
        .clr       (rx_clr_c),
        .load      (1'b0),
        .load_data ('0),
        .shift     (rx_shift_c),
        .restart   (rx_restart_c),
        .din       (SDI),
        .top_bits  (rx_frame),
        .count     (rx_count)
    );

    aes_spi_shreg #(.W(BLOCK_W), .OUT_W(1)) u_tx (
        .clk       (clk),
        .rst       (rst),
        .clr       (1'b0),
        .load      (tx_load_c),
        .load_data (aes_ciphertext),
        .shift     (tx_shift_c),
        .restart   (1'b0),
        .din       (1'b0),
        .top_bits  (tx_msb),
        .count     (tx_count)
    );

    // Frame register holds still from LAUNCH through WAIT, so the core sees a stable operand.
    assign aes_plaintext = rx_frame[FRAME-1 -: BLOCK_W];
    assign aes_key       = rx_frame[KEY_W-1:0];
    // TX register drains to zero, so its MSB is already 0 outside TX.
    assign SDO           = tx_msb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            wait_cnt     <= '0;
            aes_start    <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            err          <= 1'b0;
        end else begin
            aes_start <= 1'b0;
            err       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!CS) state <= ST_RX;
                end
                ST_RX: begin
                    if (CS) begin
                        err   <= 1'b1;
                        state <= ST_IDLE;
                    end else if (rx_count == CNT_W'(FRAME - 1)) begin
                        aes_start <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    wait_cnt <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (aes_done) begin
                        busy         <= 1'b0;
                        result_valid <= 1'b1;
                        state        <= ST_TX;
                    end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                        busy  <= 1'b0;
                        err   <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                ST_TX: begin
                    if (!CS && tx_count == CNT_W'(BLOCK_W - 1)) begin
                        result_valid <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
                default: begin
                    busy         <= 1'b0;
                    result_valid <= 1'b0;
                    state        <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_spi_ctrl.sv
// Bench for aes_spi_ctrl: queue-based reference model checked every cycle,
// plus directed frames with hand-written expected values.
module tb_aes_spi_ctrl;

    localparam int unsigned FRAME4  = 256;
    localparam int unsigned TIMEOUT = 64;

    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT2  = 128'hdeadbeef0123456789abcdeffedcba98;
    localparam logic [127:0] KEY2 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    localparam logic [127:0] CT2  = 128'ha5a50f0f3c3c123480000001fedcba98;
    localparam logic [255:0] KEY8 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic CS = 1'b1, SDI = 1'b0;
    logic CS8 = 1'b1, SDI8 = 1'b0;
    logic core_done = 1'b0, stray_done = 1'b0;
    logic [127:0] core_ct = '0;
    int core_lat = 0;
    wire aes_done = core_done | stray_done;

    logic SDO, aes_start, busy, result_valid, err;
    logic [127:0] aes_plaintext, aes_key;
    logic SDO8, start8, busy8, valid8, err8;
    logic [127:0] pt8;
    logic [255:0] key8;
    logic done8 = 1'b0;
    logic [127:0] ct8 = '0;

    int n_tests = 0, n_fail = 0;
    int start_cnt = 0, err_cnt = 0;

    always #5 clk = ~clk;

    aes_spi_ctrl #(.Nk(4), .Nr(10), .TIMEOUT(TIMEOUT)) u_dut4 (
        .clk(clk), .rst(rst), .CS(CS), .SDI(SDI), .SDO(SDO),
        .aes_start(aes_start), .aes_plaintext(aes_plaintext), .aes_key(aes_key),
        .aes_done(aes_done), .aes_ciphertext(core_ct),
        .busy(busy), .result_valid(result_valid), .err(err)
    );

    aes_spi_ctrl #(.Nk(8), .Nr(14), .TIMEOUT(TIMEOUT)) u_dut8 (
        .clk(clk), .rst(rst), .CS(CS8), .SDI(SDI8), .SDO(SDO8),
        .aes_start(start8), .aes_plaintext(pt8), .aes_key(key8),
        .aes_done(done8), .aes_ciphertext(ct8),
        .busy(busy8), .result_valid(valid8), .err(err8)
    );

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkw(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model core: done pulse core_lat cycles after the start cycle; 0 means never.
    initial begin
        int cd;
        cd = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                cd = 0;
                core_done = 1'b0;
            end else if (aes_start && core_lat > 0) begin
                cd = core_lat;
                core_done = 1'b0;
            end else if (cd > 0) begin
                cd--;
                core_done = (cd == 0);
            end else begin
                core_done = 1'b0;
            end
        end
    end

    // Reference model, phases: 0 idle, 1 receiving, 2 launch, 3 waiting, 4 sending.
    int m_phase = 0, m_wcnt = 0;
    bit rx_q[$];
    bit tx_q[$];
    logic m_start = 1'b0, m_busy = 1'b0, m_valid = 1'b0, m_err = 1'b0, m_sdo = 1'b0;
    logic [127:0] m_pt = '0, m_key = '0;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_phase = 0;
                rx_q.delete();
                tx_q.delete();
                m_start = 1'b0;
                m_err = 1'b0;
            end else begin
                m_start = 1'b0;
                m_err = 1'b0;
                case (m_phase)
                    0: if (!CS) begin
                        rx_q.delete();
                        rx_q.push_back(SDI);
                        m_phase = 1;
                    end
                    1: if (CS) begin
                        m_err = 1'b1;
                        rx_q.delete();
                        m_phase = 0;
                    end else begin
                        rx_q.push_back(SDI);
                        if (rx_q.size() == FRAME4) begin
                            for (int i = 0; i < 128; i++) begin
                                m_pt[127-i]  = rx_q[i];
                                m_key[127-i] = rx_q[128+i];
                            end
                            m_start = 1'b1;
                            m_phase = 2;
                        end
                    end
                    2: begin
                        m_wcnt = 0;
                        m_phase = 3;
                    end
                    3: if (aes_done) begin
                        tx_q.delete();
                        for (int i = 127; i >= 0; i--) tx_q.push_back(core_ct[i]);
                        m_phase = 4;
                    end else begin
                        m_wcnt++;
                        if (m_wcnt == TIMEOUT) begin
                            m_err = 1'b1;
                            m_phase = 0;
                        end
                    end
                    4: if (!CS) begin
                        void'(tx_q.pop_front());
                        if (tx_q.size() == 0) m_phase = 0;
                    end
                    default: m_phase = 0;
                endcase
            end
            m_busy  = (m_phase == 2 || m_phase == 3);
            m_valid = (m_phase == 4);
            m_sdo   = (m_phase == 4) ? tx_q[0] : 1'b0;
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            chk1("aes_start", aes_start, m_start);
            chk1("busy", busy, m_busy);
            chk1("result_valid", result_valid, m_valid);
            chk1("err", err, m_err);
            chk1("sdo", SDO, m_sdo);
            if (m_phase == 2 || m_phase == 3) begin
                chkw("plaintext", 256'(aes_plaintext), 256'(m_pt));
                chkw("key", 256'(aes_key), 256'(m_key));
            end
            if (aes_start) start_cnt++;
            if (err) err_cnt++;
        end
    end

    task automatic send_frame(input logic [383:0] bits, input int n, input bit sel);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (sel) begin
                CS8 = 1'b0;
                SDI8 = bits[n-1-i];
            end else begin
                CS = 1'b0;
                SDI = bits[n-1-i];
            end
        end
        @(posedge clk);
        #1;
        CS = 1'b1;
        SDI = 1'b0;
        CS8 = 1'b1;
        SDI8 = 1'b0;
    endtask

    task automatic recv(input int pause_at, input int pause_len, input logic [127:0] exp,
                        output logic [127:0] got);
        int bits, paused, guard;
        bit seen;
        got = '0;
        seen = 1'b0;
        guard = 0;
        while (!seen && guard < 200) begin
            @(negedge clk);
            seen = result_valid;
            guard++;
        end
        chk1("tx_valid_wait", result_valid, 1'b1);
        if (!seen) return;
        bits = 0;
        paused = 0;
        guard = 0;
        while (bits < 128 && guard < 400) begin
            guard++;
            @(posedge clk);
            #1;
            if (bits == pause_at && paused < pause_len) begin
                CS = 1'b1;
                paused++;
            end else begin
                CS = 1'b0;
            end
            @(negedge clk);
            if (CS) begin
                chk1("tx_hold", SDO, exp[127-bits]);
            end else begin
                got[127-bits] = SDO;
                bits++;
            end
        end
        @(posedge clk);
        #1;
        CS = 1'b1;
        chkw("tx_bits", 256'(bits), 256'(128));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got time %0t expected under 500000", $time);
        $fatal(1);
    end

    initial begin
        logic [127:0] got;
        int e0, s0, idx;
        bit hit;

        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_sdo", SDO, 1'b0);
        chk1("rst_start", aes_start, 1'b0);
        chkw("rst_key", 256'(aes_key), 256'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        // Known-answer frame, core responds after 10 cycles
        core_ct = CT1;
        core_lat = 10;
        send_frame({128'h0, PT1, KEY1}, 256, 1'b0);
        @(negedge clk);
        chk1("t1_launch_start", aes_start, 1'b1);
        chkw("t1_pt", 256'(aes_plaintext), 256'(PT1));
        chkw("t1_key", 256'(aes_key), 256'(KEY1));
        recv(-1, 0, CT1, got);
        chkw("t1_sdo_stream", 256'(got), 256'(CT1));
        chkw("t1_start_count", 256'(start_cnt), 256'(1));
        repeat (3) @(posedge clk);

        // Pause of 5 cycles after 40 output bits
        core_ct = CT2;
        send_frame({128'h0, PT2, KEY2}, 256, 1'b0);
        recv(40, 5, CT2, got);
        chkw("t2_sdo_stream", 256'(got), 256'(CT2));
        chkw("t2_start_count", 256'(start_cnt), 256'(2));
        repeat (3) @(posedge clk);

        // Abort after 100 bits
        e0 = err_cnt;
        s0 = start_cnt;
        send_frame({128'h0, PT2, KEY2}, 100, 1'b0);
        repeat (5) @(negedge clk);
        chkw("t3_err_pulses", 256'(err_cnt - e0), 256'(1));
        chkw("t3_no_start", 256'(start_cnt - s0), 256'(0));
        chk1("t3_busy", busy, 1'b0);

        // Stray done while idle
        @(posedge clk);
        #1 stray_done = 1'b1;
        @(posedge clk);
        #1 stray_done = 1'b0;
        @(negedge clk);
        chk1("t4_valid", result_valid, 1'b0);
        chk1("t4_busy", busy, 1'b0);

        // Core never answers: err 64 cycles after WAIT entry
        core_lat = 0;
        e0 = err_cnt;
        send_frame({128'h0, PT1, KEY2}, 256, 1'b0);
        idx = 0;
        hit = 1'b0;
        while (!hit && idx < 200) begin
            @(negedge clk);
            if (err) hit = 1'b1;
            else idx++;
        end
        chkw("t5_timeout_delay", 256'(idx - 1), 256'(TIMEOUT));
        repeat (3) @(negedge clk);
        chkw("t5_err_pulses", 256'(err_cnt - e0), 256'(1));
        chk1("t5_busy", busy, 1'b0);

        // Reset during WAIT, then a clean frame
        core_lat = 30;
        send_frame({128'h0, PT2, KEY1}, 256, 1'b0);
        repeat (5) @(posedge clk);
        e0 = err_cnt;
        #1 rst = 1'b1;
        #1;
        chk1("t6_rst_busy", busy, 1'b0);
        chk1("t6_rst_err", err, 1'b0);
        chk1("t6_rst_valid", result_valid, 1'b0);
        chk1("t6_rst_sdo", SDO, 1'b0);
        chkw("t6_rst_pt", 256'(aes_plaintext), 256'(0));
        chkw("t6_rst_key", 256'(aes_key), 256'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        chkw("t6_no_err", 256'(err_cnt - e0), 256'(0));
        core_lat = 10;
        core_ct = CT1;
        send_frame({128'h0, PT1, KEY1}, 256, 1'b0);
        recv(-1, 0, CT1, got);
        chkw("t6_sdo_stream", 256'(got), 256'(CT1));

        // 256-bit key instance
        send_frame({PT1, KEY8}, 384, 1'b1);
        @(negedge clk);
        chkw("t7_key8", key8, KEY8);
        chkw("t7_pt8", 256'(pt8), 256'(PT1));
        chk1("t7_start8", start8, 1'b1);
        chk1("t7_busy8", busy8, 1'b1);
        chk1("t7_sdo8", SDO8, 1'b0);
        chk1("t7_valid8", valid8, 1'b0);
        chk1("t7_err8", err8, 1'b0);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
